// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the DataMemory arbiter: FSM state encoding,
// port count, word-alignment mask and the latched request record.
package dm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } dm_state_e;

    localparam int          NUM_PORTS       = 2;
    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dm_req_t;

    function automatic logic [31:0] align_addr(input logic [31:0] addr);
        return addr & WORD_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/dm_arb_picker.sv
// Combinational winner select between the two requesters.
// ARB_ROUND_ROBIN_EN: ties go to the port that did not win last; otherwise port 0 wins ties.
module dm_arb_picker
    import dm_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req_valid,
    input  logic                 last_grant,
    output logic                 grant_valid,
    output logic                 grant_idx
);

`ifndef ARB_ROUND_ROBIN_EN
    logic unused_last_grant_s;
    assign unused_last_grant_s = last_grant;
`endif

    // Winner selection: a lone requester always wins, ties resolved by build mode
    always_comb begin
        grant_valid = |req_valid;
        grant_idx   = 1'b0;
        if (req_valid == 2'b11) begin
`ifdef ARB_ROUND_ROBIN_EN
            grant_idx = ~last_grant;
`else
            grant_idx = 1'b0;
`endif
        end else if (req_valid[1]) begin
            grant_idx = 1'b1;
        end else begin
            grant_idx = 1'b0;
        end
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares the single-port DataMemory between the CPU MEM stage (port 0) and the
// debug/loader port (port 1), one transaction at a time. Tie policy: ARB_ROUND_ROBIN_EN.
module data_memory_arbiter
    import dm_arb_pkg::*;
#(
    parameter int MEM_WORDS  = 1024,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  p0_req_valid,
    output logic                  p0_req_ready,
    input  logic                  p0_req_write,
    input  logic [ADDR_WIDTH-1:0] p0_req_addr,
    input  logic [DATA_WIDTH-1:0] p0_req_wdata,
    output logic                  p0_rsp_valid,
    input  logic                  p0_rsp_ready,
    output logic [DATA_WIDTH-1:0] p0_rsp_rdata,
    output logic                  p0_rsp_error,
    input  logic                  p1_req_valid,
    output logic                  p1_req_ready,
    input  logic                  p1_req_write,
    input  logic [ADDR_WIDTH-1:0] p1_req_addr,
    input  logic [DATA_WIDTH-1:0] p1_req_wdata,
    output logic                  p1_rsp_valid,
    input  logic                  p1_rsp_ready,
    output logic [DATA_WIDTH-1:0] p1_rsp_rdata,
    output logic                  p1_rsp_error,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_writeEnabled,
    output logic [DATA_WIDTH-1:0] mem_writeInput,
    input  logic [DATA_WIDTH-1:0] mem_readResult
);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_ACCESS = ACCESS;
    localparam logic [1:0] S_RESP   = RESP;
    localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(MEM_WORDS * 4);

    logic [1:0]            state_q, state_d;
    dm_req_t               req_q, req_d;
    logic                  grant_q, grant_d;
    logic                  last_grant_q, last_grant_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  error_q, error_d;

    logic                  grant_valid_s;
    logic                  grant_idx_s;
    dm_req_t               win_req_s;
    logic                  in_range_s;
    logic                  rsp_ready_s;

    dm_arb_picker u_picker (
        .req_valid   ({p1_req_valid, p0_req_valid}),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid_s),
        .grant_idx   (grant_idx_s)
    );

    // Winning request payload, word-aligned, plus its range check
    always_comb begin
        if (grant_idx_s) begin
            win_req_s.write = p1_req_write;
            win_req_s.addr  = align_addr(p1_req_addr);
            win_req_s.wdata = p1_req_wdata;
        end else begin
            win_req_s.write = p0_req_write;
            win_req_s.addr  = align_addr(p0_req_addr);
            win_req_s.wdata = p0_req_wdata;
        end
        in_range_s  = (win_req_s.addr < ADDR_LIMIT);
        rsp_ready_s = grant_q ? p1_rsp_ready : p0_rsp_ready;
    end

    // Next-state and datapath update; req_q only moves on an in-range accept so the
    // memory-side address/data hold their last value otherwise
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        rdata_d      = rdata_q;
        error_d      = error_q;
        case (state_q)
            S_IDLE: begin
                if (grant_valid_s) begin
                    grant_d      = grant_idx_s;
                    last_grant_d = grant_idx_s;
                    rdata_d      = {DATA_WIDTH{1'b0}};
                    if (in_range_s) begin
                        req_d   = win_req_s;
                        error_d = 1'b0;
                        state_d = S_ACCESS;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_RESP;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCESS: begin
                rdata_d = req_q.write ? {DATA_WIDTH{1'b0}} : mem_readResult;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready_s) begin
                    rdata_d = {DATA_WIDTH{1'b0}};
                    error_d = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            req_q        <= '{write: 1'b0, addr: 32'd0, wdata: 32'd0};
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            rdata_q      <= {DATA_WIDTH{1'b0}};
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            rdata_q      <= rdata_d;
            error_q      <= error_d;
        end
    end

    // Write enable derives from state so an asynchronous reset kills it at once
    always_comb begin
        p0_req_ready     = reset && (state_q == S_IDLE) && grant_valid_s && !grant_idx_s;
        p1_req_ready     = reset && (state_q == S_IDLE) && grant_valid_s &&  grant_idx_s;
        p0_rsp_valid     = (state_q == S_RESP) && !grant_q;
        p1_rsp_valid     = (state_q == S_RESP) &&  grant_q;
        p0_rsp_rdata     = grant_q ? {DATA_WIDTH{1'b0}} : rdata_q;
        p1_rsp_rdata     = grant_q ? rdata_q : {DATA_WIDTH{1'b0}};
        p0_rsp_error     = error_q && !grant_q;
        p1_rsp_error     = error_q &&  grant_q;
        mem_address      = req_q.addr;
        mem_writeInput   = req_q.wdata;
        mem_writeEnabled = (state_q == S_ACCESS) && req_q.write;
    end

endmodule
